transposition_ctrl: RTL
=======================

# transposition_ctrl

Sequencer for the SYSTOLIC_WIDTH×SYSTOLIC_WIDTH register-array transposition unit. It collects one matrix of row words from an upstream valid/ready stream into a local row buffer. It then drives the array's load phase (mode 0) for exactly SYSTOLIC_WIDTH contiguous cycles, followed by the read-out phase (mode 1) for SYSTOLIC_WIDTH cycles, and presents the array output as a registered valid stream. The next matrix is accepted while the current one drains, so back-to-back matrices run at one matrix every 2·SYSTOLIC_WIDTH cycles.

## Interface
- DATA_WIDTH, 16, element width in bits
- SYSTOLIC_WIDTH, 4, array dimension N (rows per matrix, elements per row); N ≥ 2

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- abort  in  1  synchronous clear of the in-flight matrix
- in_valid  in  1  upstream row valid
- in_ready  out  1  controller can accept a row
- in_data  in  N·DATA_WIDTH  upstream row
- array_mode  out  1  array mode: 0 = load, 1 = read out
- array_data  out  N·DATA_WIDTH  row driven onto the array input
- array_out  in  N·DATA_WIDTH  array output row
- out_valid  out  1  output row valid; no backpressure
- out_data  out  N·DATA_WIDTH  output row
- out_last  out  1  last row of a matrix; qualified by out_valid
- busy  out  1  matrix partly or fully in flight
- done_cnt  out  16  count of completed matrices, wraps modulo 2^16

## Operation
- Row buffer: N entries of N·DATA_WIDTH bits.
  - wr_cnt counts 0..N; a row is written at index wr_cnt on each handshake (in_valid & in_ready).
  - rd_cnt counts 0..N-1.
- States are FILL (reset state), LOAD and DRAIN.
- FILL:
  - in_ready = (wr_cnt < N); array_mode = 1; array_data = 0.
  - The handshake that brings wr_cnt to N moves the state to LOAD on the same edge.
- LOAD:
  - in_ready = 0; array_mode = 0; array_data = buf[rd_cnt]; rd_cnt increments each cycle.
  - After N cycles (rd_cnt = N-1): go to DRAIN, rd_cnt ← 0, wr_cnt ← 0.
- DRAIN:
  - array_mode = 1; array_data = 0; in_ready = (wr_cnt < N), so the buffer refills.
  - Each cycle: out_data ← array_out, out_valid ← 1, out_last ← (rd_cnt = N-1).
  - After N cycles: go to LOAD if wr_cnt = N, otherwise FILL. done_cnt increments on this edge. rd_cnt ← 0.
- Outside DRAIN, out_valid ← 0 and out_last ← 0. out_data holds its last value.
- busy = (state ≠ FILL) | (wr_cnt ≠ 0).
- abort, any state: next edge forces state = FILL, wr_cnt = 0, rd_cnt = 0, out_valid = 0, out_last = 0.
  - done_cnt is unchanged.
  - A handshake in the same cycle as abort is dropped; abort wins.
- The controller does not interpret element ordering. Transposition semantics belong to the array.

## Timing
- Reset values:
  - Registered: state FILL, wr_cnt 0, rd_cnt 0, out_valid 0, out_data 0, out_last 0, done_cnt 0.
  - Combinational: in_ready 1, array_mode 1, array_data 0, busy 0.
- Let cycle T be the cycle of the Nth handshake.
  - LOAD occupies T+1..T+N. array_data in cycle T+k carries buffer row k-1.
  - DRAIN occupies T+N+1..T+2N.
  - out_valid is high in cycles T+N+2..T+2N+1. out_last is high in cycle T+2N+1.
- Back-to-back operation: when N rows arrive during DRAIN, LOAD follows with no idle cycle. Sustained period is 2N cycles per matrix.
- Buffer full in DRAIN: in_ready = 0 until the next LOAD ends. In_valid held during LOAD is ignored and must be held by upstream.
- Reset mid-operation: all state is cleared asynchronously. The array shares rst_n, so no partial matrix survives.
- done_cnt wraps from 0xFFFF to 0x0000.

## Test plan
- Single matrix, N=4, rows 0x0001_0002_0003_0004 … 0x000D_000E_000F_0010 sent on consecutive cycles:
  - array_mode = 0 for exactly 4 cycles, then 1 for 4 cycles.
  - 4 out_valid pulses; out_last on the 4th; done_cnt = 1.
- Upstream gaps: in_valid toggled 1,0,1,0,…:
  - LOAD still starts only after the 4th handshake and remains 4 contiguous cycles.
  - Output matches the gap-free run.
- Back-to-back: 3 matrices streamed with in_valid held at 1:
  - FILL is never re-entered between matrices; matrix periods are 8 cycles; done_cnt = 3.
  - in_ready = 0 throughout every LOAD.
- Abort after 2 rows:
  - wr_cnt = 0, busy = 0; the next 4 rows form a clean matrix; done_cnt unchanged by the abort.
- Abort during DRAIN cycle 2:
  - out_valid drops the next cycle; no out_last; done_cnt unchanged; the controller is in FILL.
- Async rst_n pulse mid-LOAD:
  - All outputs return to reset values immediately (in_ready 1, array_mode 1, out_valid 0).

Source files
------------

// File: rtl/transposition_ctrl.sv
// Sequencer for the NxN register-array transposition unit: buffers one matrix of
// rows, streams it into the array (load), then registers the array read-out.
module transposition_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int SYSTOLIC_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 abort,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] in_data,
    output logic                                 array_mode,
    output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] array_data,
    input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] array_out,
    output logic                                 out_valid,
    output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] out_data,
    output logic                                 out_last,
    output logic                                 busy,
    output logic [15:0]                          done_cnt
);
    localparam int ROW_W = SYSTOLIC_WIDTH * DATA_WIDTH;
    localparam int IW    = $clog2(SYSTOLIC_WIDTH);
    localparam int CW    = $clog2(SYSTOLIC_WIDTH + 1);
    localparam logic [CW-1:0] FULL    = CW'(SYSTOLIC_WIDTH);
    localparam logic [CW-1:0] FULL_M1 = CW'(SYSTOLIC_WIDTH - 1);
    localparam logic [IW-1:0] LAST_RD = IW'(SYSTOLIC_WIDTH - 1);

    typedef enum logic [1:0] {FILL, LOAD, DRAIN} state_t;

    state_t                               state, state_nxt;
    logic [CW-1:0]                        wr_cnt;
    logic [IW-1:0]                        rd_cnt;
    logic [SYSTOLIC_WIDTH-1:0][ROW_W-1:0] row_buf;
    logic                                 wr_en, rd_last, fill_done, draining;

    assign wr_en     = in_valid & in_ready & ~abort;
    assign rd_last   = (rd_cnt == LAST_RD);
    // Counts the handshake landing on this edge so a refill finishing on the
    // last DRAIN cycle chains straight into LOAD.
    assign fill_done = (wr_cnt == FULL) || (wr_en && (wr_cnt == FULL_M1));
    assign draining  = (state == DRAIN) & ~abort;
    assign busy      = (state != FILL) || (wr_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= FILL;
        else if (abort)
            state <= FILL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (fill_done) state_nxt = LOAD;
            LOAD:    if (rd_last)   state_nxt = DRAIN;
            DRAIN:   if (rd_last)   state_nxt = fill_done ? LOAD : FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        array_mode = 1'b1;
        array_data = '0;
        case (state)
            FILL, DRAIN: in_ready = (wr_cnt != FULL);
            LOAD: begin
                array_mode = 1'b0;
                array_data = row_buf[rd_cnt];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (abort) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (state == LOAD && rd_last)
                wr_cnt <= '0;
            else if (wr_en)
                wr_cnt <= wr_cnt + CW'(1);
            if (state == FILL || rd_last)
                rd_cnt <= '0;
            else
                rd_cnt <= rd_cnt + IW'(1);
        end
    end

    // Write index is always below N here because in_ready gates wr_en.
    always_ff @(posedge clk) begin
        if (wr_en)
            row_buf[wr_cnt[IW-1:0]] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            done_cnt  <= '0;
        end else begin
            out_valid <= draining;
            out_last  <= draining & rd_last;
            if (draining)
                out_data <= array_out;
            if (draining && rd_last)
                done_cnt <= done_cnt + 16'd1;
        end
    end
endmodule
